// File: rtl/signed32bit_div_seq_if.sv
// Start/done handshake bundle for the sequential signed divider.
// master issues operands, slave returns results and status.
interface signed32bit_div_seq_if #(parameter int W = 32);
    logic                start;
    logic signed [W-1:0] dividend;
    logic signed [W-1:0] divisor;
    logic                busy;
    logic                done;
    logic signed [W-1:0] quotient;
    logic signed [W-1:0] remainder;
    logic                dbz;
    logic                ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/signed32bit_div_seq.sv
// Sequential signed divider: one restoring shift-subtract step per clock on magnitudes,
// sign correction and divide-by-zero / overflow handling applied in a final FIX cycle.
module signed32bit_div_seq #(
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    signed32bit_div_seq_if.slave   bus
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [1:0]          state;
    logic [CW-1:0]       cnt;

    // Working registers: W unsigned bits hold |-2^(W-1)| exactly.
    logic [W-1:0]        q_mag;
    logic [W-1:0]        d_mag;
    logic [W-1:0]        r_mag;
    logic                sign_q;
    logic                sign_r;
    logic                dbz_case;
    logic                ovf_case;
    logic signed [W-1:0] dvd_hold;

    logic [W:0]          r_shift;
    logic                r_ge;
    logic [W-1:0]        q_shift;

    logic                done_r;
    logic                dbz_r;
    logic                ovf_r;
    logic signed [W-1:0] quot_r;
    logic signed [W-1:0] rem_r;

    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
        logic [W-1:0] u;
        u = x;
        return x[W-1] ? (~u + {{(W-1){1'b0}}, 1'b1}) : u;
    endfunction

    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] m, input logic neg);
        logic [W-1:0] res;
        res = neg ? (~m + {{(W-1){1'b0}}, 1'b1}) : m;
        return $signed(res);
    endfunction

    always_comb begin
        r_shift = {1'b0, r_mag[W-1:0], q_mag[W-1]};
        r_shift = r_shift[W:0];
        r_ge    = (r_shift >= {1'b0, d_mag});
        q_shift = {q_mag[W-2:0], r_ge};
    end

    // Operand capture and iteration datapath; not reset, qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            q_mag    <= magnitude(bus.dividend);
            d_mag    <= magnitude(bus.divisor);
            r_mag    <= '0;
            sign_q   <= bus.dividend[W-1] ^ bus.divisor[W-1];
            sign_r   <= bus.dividend[W-1];
            dvd_hold <= bus.dividend;
            dbz_case <= (bus.divisor == '0);
            ovf_case <= (bus.dividend == MIN_VAL) && (bus.divisor == {W{1'b1}});
        end else if (state == RUN) begin
            r_mag <= r_ge ? W'(r_shift - {1'b0, d_mag}) : r_shift[W-1:0];
            q_mag <= q_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            state <= FIX;
                            cnt   <= '0;
                        end else begin
                            state <= RUN;
                            cnt   <= CW'(W);
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                    if (dbz_case) begin
                        quot_r <= '1;
                        rem_r  <= dvd_hold;
                        dbz_r  <= 1'b1;
                        ovf_r  <= 1'b0;
                    end else if (ovf_case) begin
                        quot_r <= MIN_VAL;
                        rem_r  <= '0;
                        dbz_r  <= 1'b0;
                        ovf_r  <= 1'b1;
                    end else begin
                        quot_r <= apply_sign(q_mag, sign_q);
                        rem_r  <= apply_sign(r_mag, sign_r);
                        dbz_r  <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_signed32bit_div_seq.sv
// Scoreboard bench for the sequential signed divider: a driver queues expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_signed32bit_div_seq;
    localparam int W = 32;
    localparam logic signed [31:0] MINV = 32'sh8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signed32bit_div_seq_if #(.W(W)) bus ();
    signed32bit_div_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic               dbz;
        logic               ovf;
        int                 lat;
        int                 acc;
        bit                 b2b;
        bit                 inv;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   busy_run = 0;
    int   prev_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done q=%h r=%h at cycle %0d", bus.quotient, bus.remainder, cyc);
                end else begin
                    m = sb.pop_front();
                    check("quotient", bus.quotient, m.q);
                    check("remainder", bus.remainder, m.r);
                    check("dbz", {31'd0, bus.dbz}, {31'd0, m.dbz});
                    check("ovf", {31'd0, bus.ovf}, {31'd0, m.ovf});
                    check("latency", cyc - m.acc, m.lat);
                    check("busy_cycles", busy_run, m.lat);
                    check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
                    if (m.b2b) check("b2b_period", cyc - prev_done, W + 2);
                    if (m.inv) begin
                        check("invariant", m.a, bus.quotient * m.b + bus.remainder);
                        check("rem_bound", {31'd0, labs(longint'(bus.remainder)) < labs(longint'(m.b))}, 32'd1);
                    end
                end
                prev_done = cyc;
                busy_run  = 0;
            end
        end
    end

    task automatic issue(input logic signed [31:0] a, input logic signed [31:0] b,
                         input logic signed [31:0] q, input logic signed [31:0] r,
                         input logic dbz, input logic ovf, input bit b2b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.a   = a;
        e.b   = b;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.ovf = ovf;
        e.lat = (b == 0) ? 1 : W + 1;
        e.acc = cyc;
        e.b2b = b2b;
        e.inv = !(dbz || ovf);
        sb.push_back(e);
    endtask

    task automatic issue_model(input logic signed [31:0] a, input logic signed [31:0] b);
        if (b == 0)
            issue(a, b, -32'sd1, a, 1'b1, 1'b0, 1'b0);
        else if (a == MINV && b == -32'sd1)
            issue(a, b, MINV, 32'sd0, 1'b0, 1'b1, 1'b0);
        else
            issue(a, b, a / b, a % b, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int  n;
        bit  saw;
        logic signed [31:0] ra;
        logic signed [31:0] rb;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_dbz", {31'd0, bus.dbz}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

        issue(100, 7, 14, 2, 1'b0, 1'b0, 1'b0);
        // A start pulse in the middle of RUN must be ignored.
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5;
        bus.divisor  = 1;
        @(posedge clk);
        #1 bus.start = 1'b0;

        issue(-100, 7, -14, -2, 1'b0, 1'b0, 1'b0);
        issue(100, -7, -14, 2, 1'b0, 1'b0, 1'b0);
        issue(-100, -7, 14, -2, 1'b0, 1'b0, 1'b0);
        issue(1000, 10, 100, 0, 1'b0, 1'b0, 1'b0);
        issue(-1000, 3, -333, -1, 1'b0, 1'b0, 1'b1);
        issue(77, -8, -9, 5, 1'b0, 1'b0, 1'b1);
        issue(123, 0, -32'sd1, 123, 1'b1, 1'b0, 1'b0);
        issue(MINV, -1, MINV, 0, 1'b0, 1'b1, 1'b0);
        issue(MINV, 1, MINV, 0, 1'b0, 1'b0, 1'b0);
        issue(MINV, 0, -32'sd1, MINV, 1'b1, 1'b0, 1'b0);
        issue(32'sh7FFF_FFFF, MINV, 0, 32'sh7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        issue(MINV, MINV, 1, 0, 1'b0, 1'b0, 1'b0);
        issue(-1, MINV, 0, -1, 1'b0, 1'b0, 1'b0);
        issue(0, 5, 0, 0, 1'b0, 1'b0, 1'b0);

        // Abort: reset lands on RUN iteration 10 of a 100/7.
        issue(100, 7, 14, 2, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_dbz", {31'd0, bus.dbz}, 32'd0);
        check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        check("abort_no_done", {31'd0, saw}, 32'd0);

        issue(7, 2, 3, 1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = 32'($urandom >> $urandom_range(31, 0));
            if ($urandom_range(1, 0) == 1) rb = -rb;
            issue_model(ra, rb);
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
